// File: rtl/crc8_frame_arb.sv
// Two-requester, frame-granular arbiter in front of an external 32-bit CRC8 core.
// Each granted frame re-initialises the core, streams its beats, and returns one CRC result.
module crc8_frame_arb #(
    parameter int MAX_BEATS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_crc,
    output logic        res_id,
    output logic        res_err,
    output logic [31:0] core_data,
    output logic        core_en,
    output logic        core_rst_n,
    input  logic [7:0]  core_crc
);

    // Handshakes: a beat moves when req_valid[g] and req_ready[g] are both high at a
    // rising edge; a result moves when res_valid and res_ready are both high.

    typedef enum logic [2:0] {IDLE, INIT, RUN, DONE, RESULT} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       err_q, err_d;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        req_ready  = 2'b00;
        core_en    = 1'b0;
        core_data  = 32'd0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = (&req_valid) ? rr_ptr_q : req_valid[1];
                    state_d = INIT;
                end
            end
            INIT: begin
                beat_cnt_d = 8'd0;
                state_d    = RUN;
            end
            RUN: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    core_en    = 1'b1;
                    core_data  = grant_q ? req_data1 : req_data0;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (req_last[grant_q]) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else if (beat_cnt_q + 8'd1 == MAX_B) begin
                        // Truncated: remaining beats of this requester form a new frame.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    rr_ptr_d = ~grant_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            req_ready = 2'b00;
            core_en   = 1'b0;
            core_data = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= 8'd0;
            err_q      <= 1'b0;
            res_crc    <= 8'h00;
            res_id     <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            if (state_q == DONE) begin
                res_crc <= core_crc;
                res_id  <= grant_q;
                res_err <= err_q;
            end
        end
    end

    assign res_valid  = rst_n && (state_q == RESULT);
    assign core_rst_n = rst_n && (state_q != INIT);

endmodule

// File: tb/tb_crc8_frame_arb.sv
// Bench for crc8_frame_arb: models the external CRC8 core and scores results
// against expectations queued when each frame is driven.
module tb_crc8_frame_arb;

    localparam int MAX_BEATS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [31:0] d0 = 32'd0, d1 = 32'd0;
    logic        res_ready = 1'b0;
    logic [1:0]  req_valid, req_last, req_ready;
    logic        res_valid, res_id, res_err, core_en, core_rst_n;
    logic [7:0]  res_crc, core_crc;
    logic [31:0] core_data;

    assign req_valid = {v1, v0};
    assign req_last  = {l1, l0};

    crc8_frame_arb #(.MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data0(d0), .req_data1(d1), .req_last(req_last),
        .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_crc(res_crc), .res_id(res_id), .res_err(res_err),
        .core_data(core_data), .core_en(core_en), .core_rst_n(core_rst_n),
        .core_crc(core_crc)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // x^8+x^4+x^3+x^2+1, MSB-first over the 32-bit word
    function automatic logic [7:0] crc8_word(input logic [7:0] c, input logic [31:0] w);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[7] ^ w[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!core_rst_n) core_crc <= 8'hFF;
        else if (core_en) core_crc <= crc8_word(core_crc, core_data);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: {id, err, crc}
    logic [9:0]  exp_q[$];
    logic [31:0] core_q[$];
    logic        core_chk = 1'b0;
    logic [9:0]  exp_item;

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) check("res_unexpected", 32'd1, 32'd0);
            else begin
                exp_item = exp_q.pop_front();
                check("res", 32'({res_id, res_err, res_crc}), 32'(exp_item));
            end
        end
        if (core_chk) begin
            if (core_en) begin
                if (core_q.size() == 0) check("core_unexpected", 32'd1, 32'd0);
                else check("core_data", core_data, core_q.pop_front());
            end else begin
                check("core_idle_data", core_data, 32'd0);
            end
        end
    end

    // driver tasks
    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_beat(input int id, input logic [31:0] w, input logic last);
        int t;
        if (id == 0) begin v0 = 1'b1; d0 = w; l0 = last; end
        else begin v1 = 1'b1; d1 = w; l1 = last; end
        if (core_chk) core_q.push_back(w);
        t = 0;
        @(negedge clk);
        while (!req_ready[id] && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[id]) check("beat_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) begin v0 = 1'b0; l0 = 1'b0; end
        else begin v1 = 1'b0; l1 = 1'b0; end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] w[6];
    logic [7:0]  c;
    int          t0, tn, t;

    initial begin
        // reset state
        @(negedge clk);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        apply_reset();
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_fields", 32'({res_id, res_err, res_crc}), 32'd0);
        check("rst_core_en", 32'(core_en), 32'd0);
        check("idle_core_rst_n", 32'(core_rst_n), 32'd1);

        // single zero beat, known CRC and latencies
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        core_chk  = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 8'hA6});
        core_q.push_back(32'd0);
        v0 = 1'b1; d0 = 32'd0; l0 = 1'b1;
        t0 = cyc;
        t  = 0;
        @(negedge clk);
        while (!req_ready[0] && t < 20) begin @(negedge clk); t++; end
        check("ready_latency", 32'(cyc - t0), 32'd2);
        tn = cyc;
        @(posedge clk);
        #1 v0 = 1'b0; l0 = 1'b0;
        t = 0;
        @(negedge clk);
        while (!res_valid && t < 20) begin @(negedge clk); t++; end
        check("res_latency", 32'(cyc - tn), 32'd2);
        drain();

        // round robin from reset, res_ready tied high
        core_chk = 1'b0;
        apply_reset();
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        exp_q.push_back({1'b0, 1'b0, crc8_word(8'hFF, w[0])});
        exp_q.push_back({1'b1, 1'b0, crc8_word(8'hFF, w[1])});
        exp_q.push_back({1'b0, 1'b0, crc8_word(8'hFF, w[2])});
        exp_q.push_back({1'b1, 1'b0, crc8_word(8'hFF, w[3])});
        fork
            begin drive_beat(0, w[0], 1'b1); drive_beat(0, w[2], 1'b1); end
            begin drive_beat(1, w[1], 1'b1); drive_beat(1, w[3], 1'b1); end
        join
        drain();

        // req1, three beats with valid gaps
        core_chk = 1'b1;
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        c = crc8_word(crc8_word(crc8_word(8'hFF, w[0]), w[1]), w[2]);
        exp_q.push_back({1'b1, 1'b0, c});
        drive_beat(1, w[0], 1'b0);
        gap($urandom_range(1, 3));
        drive_beat(1, w[1], 1'b0);
        gap($urandom_range(1, 3));
        drive_beat(1, w[2], 1'b1);
        drain();
        check("core_q_empty", 32'(core_q.size()), 32'd0);

        // truncation at MAX_BEATS
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        c = 8'hFF;
        for (int i = 0; i < 4; i++) c = crc8_word(c, w[i]);
        exp_q.push_back({1'b0, 1'b1, c});
        exp_q.push_back({1'b0, 1'b0, crc8_word(crc8_word(8'hFF, w[4]), w[5])});
        for (int i = 0; i < 6; i++) drive_beat(0, w[i], (i == 5));
        drain();
        check("trunc_core_q_empty", 32'(core_q.size()), 32'd0);

        // result stall with res_ready low, competing request must wait
        core_chk  = 1'b0;
        res_ready = 1'b0;
        w[0] = $urandom;
        w[1] = $urandom;
        exp_q.push_back({1'b0, 1'b0, crc8_word(8'hFF, w[0])});
        drive_beat(0, w[0], 1'b1);
        t = 0;
        @(negedge clk);
        while (!res_valid && t < 20) begin @(negedge clk); t++; end
        v1 = 1'b1; d1 = w[1]; l1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_res", 32'({res_id, res_err, res_crc}),
                  32'({1'b0, 1'b0, crc8_word(8'hFF, w[0])}));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        exp_q.push_back({1'b1, 1'b0, crc8_word(8'hFF, w[1])});
        @(posedge clk);
        #1 res_ready = 1'b1;
        drive_beat(1, w[1], 1'b1);
        drain();

        // reset mid-RUN after two beats
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        drive_beat(0, w[0], 1'b0);
        drive_beat(0, w[1], 1'b0);
        rst_n = 1'b0;
        v0 = 1'b1; d0 = 32'hFFFF_FFFF; l0 = 1'b0;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_core_en", 32'(core_en), 32'd0);
        check("mid_rst_core_data", core_data, 32'd0);
        check("mid_rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1; v0 = 1'b0;
        @(negedge clk);
        check("post_rst_res_fields", 32'({res_id, res_err, res_crc}), 32'd0);
        check("post_rst_req_ready", 32'(req_ready), 32'd0);
        exp_q.push_back({1'b0, 1'b0, crc8_word(8'hFF, w[2])});
        drive_beat(0, w[2], 1'b1);
        drain();

        gap(5);
        check("exp_left", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_frame_arb.md
CRC8_FRAME_ARB -- requirements
Module: crc8_frame_arb

Interface
REQ-001 The module SHALL have parameter MAX_BEATS, default 64, which is the maximum number of 32-bit beats per frame (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port req_valid, input, 2 bits: per-requester beat valid; index 0 or 1.
REQ-005 The module SHALL have ports req_data0 and req_data1, input, 32 bits each: per-requester beat data.
REQ-006 The module SHALL have port req_last, input, 2 bits: per-requester marker for the final beat of a frame.
REQ-007 The module SHALL have port req_ready, output, 2 bits: per-requester beat accept.
REQ-008 The module SHALL have port res_valid, output, 1 bit: a frame result is available.
REQ-009 The module SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The module SHALL have port res_crc, output, 8 bits: the CRC8 of the frame (poly 1+x^2+x^3+x^4+x^8, init 0xFF).
REQ-011 The module SHALL have port res_id, output, 1 bit: the requester that owns the result.
REQ-012 The module SHALL have port res_err, output, 1 bit: the frame was truncated at MAX_BEATS.
REQ-013 The module SHALL have port core_data, output, 32 bits: drives the external 32-bit CRC8 core data_in.
REQ-014 The module SHALL have port core_en, output, 1 bit: drives the core crc_en.
REQ-015 The module SHALL have port core_rst_n, output, 1 bit: drives the core rst_n; asserting it low loads 0xFF into the core.
REQ-016 The module SHALL have port core_crc, input, 8 bits: the core crc_out, registered inside the core.

Function
REQ-017 The module SHALL implement FSM states IDLE, INIT, RUN, DONE and RESULT.
REQ-018 In IDLE, if any req_valid bit is high, the module SHALL latch grant_id and go to INIT:
- both requesters valid: grant rr_ptr;
- one requester valid: grant that requester.
REQ-019 In INIT, core_rst_n SHALL be 0 for exactly one cycle; the module SHALL then go to RUN and clear beat_cnt to 0.
REQ-020 The module SHALL drive core_rst_n = rst_n AND (state != INIT), combinationally.
REQ-021 In RUN, req_ready[grant_id] SHALL be 1 and the other bit 0; req_ready SHALL be 00 in every other state.
REQ-022 On a RUN beat (req_valid[g] AND req_ready[g]):
- core_en=1 and core_data=req_data of g in the same cycle;
- beat_cnt increments.
REQ-023 core_en SHALL be 0 and core_data SHALL be 0 whenever no beat is accepted.
REQ-024 On an accepted beat with req_last[g]=1, the module SHALL go to DONE with err_q=0.
REQ-025 On an accepted beat with req_last[g]=0 and beat_cnt+1 == MAX_BEATS, the module SHALL go to DONE with err_q=1 (truncation); later beats from that requester start a new frame.
REQ-026 In DONE (one cycle), the module SHALL capture res_crc<=core_crc, res_id<=grant_id and res_err<=err_q, then go to RESULT.
REQ-027 In RESULT, res_valid SHALL be 1, and res_crc, res_id and res_err SHALL be held stable until res_ready=1.
REQ-028 On the RESULT handshake, the module SHALL:
- set res_valid to 0 in the next cycle;
- set rr_ptr <= ~grant_id;
- go to IDLE.
REQ-029 Latency SHALL be as follows:
- last beat accepted in cycle N gives res_valid high in cycle N+2;
- first req_ready comes 2 cycles after req_valid is seen in IDLE.
REQ-030 Grants SHALL be frame-granular: no preemption mid-frame, and req_valid of the non-granted requester is ignored until IDLE.
REQ-031 A granted requester that drops req_valid in RUN SHALL stall the FSM in RUN indefinitely, with no timeout.
REQ-032 beat_cnt SHALL be 8 bits and SHALL never wrap, since it is bounded by MAX_BEATS.
REQ-033 A res_ready that is high outside RESULT SHALL be ignored.

Reset
REQ-034 While rst_n=0 at a clock edge, the module SHALL load:
- state=IDLE, rr_ptr=0, beat_cnt=0;
- res_valid=0, res_crc=0x00, res_id=0, res_err=0.
REQ-035 During reset, req_ready=00, core_en=0, core_data=0 and core_rst_n=0.
REQ-036 Reset mid-frame or mid-RESULT SHALL discard the frame and its result; the first frame after reset re-runs INIT.

Verification
REQ-037 The bench SHALL cover: req0 single beat 0x00000000 with last=1 -> res_valid at N+2, res_crc=0xA6, res_id=0, res_err=0.
REQ-038 The bench SHALL cover: both requesters valid from reset, 1-beat frames each, res_ready tied 1 -> order req0, req1, req0, req1.
REQ-039 The bench SHALL cover: req1 frame of 3 beats with req_valid gaps -> core_en only on accepted beats; res_crc matches a 3-word core model.
REQ-040 The bench SHALL cover: MAX_BEATS=4, req0 sends 6 beats with last only on beat 6 -> result 1 has res_err=1 (beats 1-4); result 2 has res_err=0 (beats 5-6, fresh 0xFF init).
REQ-041 The bench SHALL cover: res_ready held 0 for 5 cycles in RESULT -> outputs stable, req_ready=00, no new grant.
REQ-042 The bench SHALL cover: rst_n low for 1 cycle mid-RUN after beat 2 -> all outputs at reset values; the next frame yields the same CRC as if from a clean start.
